// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER job scheduler.
package laser_pkg;

    localparam int NPTS_DEF = 40;
    localparam int COORD_W  = 4;
    localparam int TO_W     = 18;
    localparam int CNT_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_BURST = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } sched_state_t;

    // One returned job result: both circle centres plus status and owner.
    typedef struct packed {
        logic [COORD_W-1:0] c1x;
        logic [COORD_W-1:0] c1y;
        logic [COORD_W-1:0] c2x;
        logic [COORD_W-1:0] c2y;
        logic               err;
        logic               id;
    } result_t;

    // Round-robin pick between two requesters: the one that was not granted
    // last wins a tie. Returns a one-hot grant, or zero when nobody asks.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (last) begin
            if (req[0])      g = 2'b01;
            else if (req[1]) g = 2'b10;
        end else begin
            if (req[1])      g = 2'b10;
            else if (req[0]) g = 2'b01;
        end
        return g;
    endfunction

endpackage

// File: rtl/laser_pt_buf.sv
// Point buffer: NPTS x 8-bit register file, one write port, one
// combinational read port indexed by the burst counter.
module laser_pt_buf
    import laser_pkg::*;
#(
    parameter int NPTS = NPTS_DEF
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [CNT_W-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [NPTS];

    // Store one point; contents need no reset, every job rewrites them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/laser_job_sched.sv
// Shares one LASER circle-cover engine between two requesters: round-robin
// grant, buffer the 40-point set, stream it gap-free to the engine, wait for
// DONE (with timeout) and return the tagged result.
//
// Handshakes: pvalid_i/pready_o transfers a point on every rising edge where
// both are high; res_valid_o/res_ready_i transfers the result on every rising
// edge where both are high, and res_* stays stable while res_valid_o is high
// and res_ready_i is low. req_i is a level held until granted or withdrawn.
module laser_job_sched
    import laser_pkg::*;
#(
    parameter int NPTS      = NPTS_DEF,
    parameter int TO_CYCLES = 200000
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [1:0]         req_i,
    output logic [1:0]         gnt_o,
    input  logic               pvalid_i,
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    output logic               pready_o,
    output logic               core_rst_o,
    output logic [COORD_W-1:0] core_x_o,
    output logic [COORD_W-1:0] core_y_o,
    input  logic               core_done_i,
    input  logic [COORD_W-1:0] core_c1x_i,
    input  logic [COORD_W-1:0] core_c1y_i,
    input  logic [COORD_W-1:0] core_c2x_i,
    input  logic [COORD_W-1:0] core_c2y_i,
    output logic               res_valid_o,
    output logic               res_id_o,
    output logic               res_err_o,
    output logic [COORD_W-1:0] res_c1x_o,
    output logic [COORD_W-1:0] res_c1y_o,
    output logic [COORD_W-1:0] res_c2x_o,
    output logic [COORD_W-1:0] res_c2y_o,
    input  logic               res_ready_i,
    output logic               busy_o,
    output logic [2:0]         dbg_state_o
);

    localparam logic [CNT_W-1:0] LAST_PT = CNT_W'(NPTS - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYCLES - 1);

    sched_state_t       state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic               pready_q, pready_d;
    logic               core_rst_q, core_rst_d;
    logic [COORD_W-1:0] core_x_q, core_x_d;
    logic [COORD_W-1:0] core_y_q, core_y_d;
    result_t            res_q, res_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;

    logic               buf_we;
    logic [7:0]         buf_rdata;
    logic [1:0]         pick;

    laser_pt_buf #(.NPTS(NPTS)) u_pt_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (wcnt_q),
        .wdata_i ({px_i, py_i}),
        .raddr_i (bcnt_q),
        .rdata_o (buf_rdata)
    );

    // Next-state and registered-output logic for the job FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        bcnt_d      = bcnt_q;
        tcnt_d      = tcnt_q;
        core_rst_d  = 1'b1;
        core_x_d    = core_x_q;
        core_y_d    = core_y_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        buf_we      = 1'b0;
        pick        = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                wcnt_d = '0;
                if (|req_i) begin
                    pick    = rr_pick(req_i, last_q);
                    gnt_d   = pick;
                    last_d  = pick[1];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A withdrawn request abandons the job; no result is produced.
                if (!(|(req_i & gnt_q))) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else if (pvalid_i && pready_q) begin
                    buf_we = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_PT) begin
                        gnt_d   = 2'b00;
                        bcnt_d  = '0;
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                // Output register delays the point by one edge, so core reset
                // falls together with point 0 appearing on the bus.
                core_rst_d = 1'b0;
                core_x_d   = buf_rdata[7:4];
                core_y_d   = buf_rdata[3:0];
                bcnt_d     = bcnt_q + 1'b1;
                if (bcnt_q == LAST_PT) begin
                    tcnt_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                core_rst_d = 1'b0;
                tcnt_d     = tcnt_q + 1'b1;
                // DONE takes priority over a coincident timeout.
                if (core_done_i) begin
                    res_d.c1x   = core_c1x_i;
                    res_d.c1y   = core_c1y_i;
                    res_d.c2x   = core_c2x_i;
                    res_d.c2y   = core_c2y_i;
                    res_d.err   = 1'b0;
                    res_d.id    = last_q;
                    res_valid_d = 1'b1;
                    core_rst_d  = 1'b1;
                    state_d     = ST_RESP;
                end else if (tcnt_q == TO_LAST) begin
                    res_d       = '0;
                    res_d.err   = 1'b1;
                    res_d.id    = last_q;
                    res_valid_d = 1'b1;
                    core_rst_d  = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pready_d = (state_d == ST_LOAD);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers; reset returns every output to its idle value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            last_q      <= 1'b1;
            wcnt_q      <= '0;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            pready_q    <= 1'b0;
            core_rst_q  <= 1'b1;
            core_x_q    <= '0;
            core_y_q    <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            bcnt_q      <= bcnt_d;
            tcnt_q      <= tcnt_d;
            pready_q    <= pready_d;
            core_rst_q  <= core_rst_d;
            core_x_q    <= core_x_d;
            core_y_q    <= core_y_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign pready_o    = pready_q;
    assign core_rst_o  = core_rst_q;
    assign core_x_o    = core_x_q;
    assign core_y_o    = core_y_q;
    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_q.id;
    assign res_err_o   = res_q.err;
    assign res_c1x_o   = res_q.c1x;
    assign res_c1y_o   = res_q.c1y;
    assign res_c2x_o   = res_q.c2x;
    assign res_c2y_o   = res_q.c2y;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_laser_job_sched.sv
// Bench for laser_job_sched: random point sets with gaps, a behavioural
// engine model, and a round-robin reference kept as "who was served last".
module tb_laser_job_sched;
    import laser_pkg::*;

    localparam int NPTS  = 40;
    localparam int TO_T  = 100;
    localparam int CLK_P = 10;

    logic       clk_i, rst_n_i;
    logic [1:0] req_i, gnt_o;
    logic       pvalid_i, pready_o;
    logic [3:0] px_i, py_i;
    logic       core_rst_o, core_done_i;
    logic [3:0] core_x_o, core_y_o;
    logic [3:0] core_c1x_i, core_c1y_i, core_c2x_i, core_c2y_i;
    logic       res_valid_o, res_id_o, res_err_o, res_ready_i, busy_o;
    logic [3:0] res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o;
    logic [2:0] dbg_state_o;

    laser_job_sched #(.NPTS(NPTS), .TO_CYCLES(TO_T)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .gnt_o(gnt_o),
        .pvalid_i(pvalid_i), .px_i(px_i), .py_i(py_i), .pready_o(pready_o),
        .core_rst_o(core_rst_o), .core_x_o(core_x_o), .core_y_o(core_y_o),
        .core_done_i(core_done_i), .core_c1x_i(core_c1x_i), .core_c1y_i(core_c1y_i),
        .core_c2x_i(core_c2x_i), .core_c2y_i(core_c2y_i),
        .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_err_o(res_err_o),
        .res_c1x_o(res_c1x_o), .res_c1y_o(res_c1y_o), .res_c2x_o(res_c2x_o),
        .res_c2y_o(res_c2y_o), .res_ready_i(res_ready_i), .busy_o(busy_o),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #(CLK_P/2) clk_i = ~clk_i;
    end

    int n_pass = 0;
    int n_total = 0;
    int m_last = 1;                    // reference: index served most recently
    logic [7:0] exp_q[$];              // points sent to the buffer
    logic [7:0] got_q[$];              // points the engine captured
    logic [15:0] eng_res;
    bit   eng_en;
    int   eng_delay;
    logic eng_done, stray_done;
    time  done_time;

    assign core_done_i = eng_done | stray_done;

    // engine model: captures NPTS points on consecutive cycles after its reset
    // drops, then pulses DONE once with eng_res after eng_delay cycles
    initial begin
        int cap_cnt;
        int dly;
        cap_cnt = 0; dly = 0; eng_done = 1'b0; done_time = 0;
        {core_c1x_i, core_c1y_i, core_c2x_i, core_c2y_i} = 16'h0;
        forever begin
            @(negedge clk_i);
            if (eng_done) begin
                eng_done = 1'b0;
                {core_c1x_i, core_c1y_i, core_c2x_i, core_c2y_i} = 16'($urandom);
            end
            if (core_rst_o) begin
                cap_cnt = 0;
            end else if (cap_cnt < NPTS) begin
                got_q.push_back({core_x_o, core_y_o});
                cap_cnt++;
                dly = eng_delay;
            end else if (cap_cnt == NPTS && eng_en) begin
                if (dly == 0) begin
                    eng_done = 1'b1;
                    {core_c1x_i, core_c1y_i, core_c2x_i, core_c2y_i} = eng_res;
                    done_time = $time;
                    cap_cnt++;
                end else begin
                    dly--;
                end
            end
        end
    end

    function automatic logic [1:0] model_pick(input logic [1:0] r);
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (m_last + k) % 2;
            if (r[c]) return 2'(1 << c);
        end
        return 2'b00;
    endfunction

    // driver + checks for one complete job
    task automatic do_job(input logic [1:0] req_val, input bit keep_req,
                          input bit exp_err, input int bp_cycles, input bit stray);
        logic [1:0]  exp_gnt;
        logic [15:0] exp_res;
        logic [7:0]  pt;
        int wait_n, sent, wait_cyc, bad_idx;
        bit ok;
        exp_gnt = model_pick(req_val);
        exp_res = exp_err ? 16'h0 : eng_res;
        exp_q.delete();
        got_q.delete();
        req_i = req_val;
        wait_n = 0;
        while (gnt_o == 2'b00 && wait_n < 20) begin
            @(negedge clk_i);
            wait_n++;
        end
        n_total++;
        if (gnt_o !== exp_gnt) $display("FAIL grant: got %b want %b", gnt_o, exp_gnt);
        else n_pass++;
        m_last = (exp_gnt == 2'b10) ? 1 : 0;

        sent = 0; ok = 1'b1; wait_n = 0;
        while (sent < NPTS && wait_n < 1000) begin
            if (gnt_o !== exp_gnt || pready_o !== 1'b1) ok = 1'b0;
            stray_done = (stray && sent == 10);
            if ($urandom_range(0, 2) == 0) begin
                pvalid_i = 1'b0;
            end else begin
                pvalid_i = 1'b1;
                pt = 8'($urandom);
                px_i = pt[7:4];
                py_i = pt[3:0];
                exp_q.push_back(pt);
                sent++;
            end
            @(negedge clk_i);
            wait_n++;
        end
        pvalid_i = 1'b0;
        stray_done = 1'b0;
        n_total++;
        if (!ok || sent != NPTS) $display("FAIL load_phase: held=%0d sent=%0d want held=1 sent=%0d", ok, sent, NPTS);
        else n_pass++;
        n_total++;
        if (gnt_o !== 2'b00 || pready_o !== 1'b0) $display("FAIL gnt_clear: gnt=%b pready=%b want 00/0", gnt_o, pready_o);
        else n_pass++;
        if (!keep_req) req_i = 2'b00;

        wait_n = 0; wait_cyc = 0;
        while (res_valid_o !== 1'b1 && wait_n < 500) begin
            if (dbg_state_o == ST_WAIT) wait_cyc++;
            @(negedge clk_i);
            wait_n++;
        end
        n_total++;
        if (res_valid_o !== 1'b1) $display("FAIL res_valid_timeout: res_valid=%b after %0d cycles", res_valid_o, wait_n);
        else n_pass++;
        n_total++;
        if (exp_err) begin
            if (wait_cyc != TO_T) $display("FAIL timeout_len: got %0d wait cycles want %0d", wait_cyc, TO_T);
            else n_pass++;
        end else begin
            if ($time - done_time != CLK_P) $display("FAIL done_latency: got %0t want %0d", $time - done_time, CLK_P);
            else n_pass++;
        end
        n_total++;
        if ({res_id_o, res_err_o} !== {exp_gnt[1], exp_err})
            $display("FAIL res_tag: id/err=%b%b want %b%b", res_id_o, res_err_o, exp_gnt[1], exp_err);
        else n_pass++;
        n_total++;
        if ({res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o} !== exp_res)
            $display("FAIL res_coords: got %h want %h", {res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o}, exp_res);
        else n_pass++;
        bad_idx = -1;
        for (int i = 0; i < NPTS; i++) begin
            if (bad_idx < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad_idx = i;
        end
        n_total++;
        if (bad_idx >= 0 || got_q.size() != NPTS)
            $display("FAIL stream: first bad index %0d, captured %0d points want %0d in order", bad_idx, got_q.size(), NPTS);
        else n_pass++;

        ok = 1'b1;
        for (int i = 0; i < bp_cycles; i++) begin
            if (res_valid_o !== 1'b1 || gnt_o !== 2'b00 || res_id_o !== exp_gnt[1] ||
                res_err_o !== exp_err || {res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o} !== exp_res) ok = 1'b0;
            @(negedge clk_i);
        end
        n_total++;
        if (!ok) $display("FAIL backpressure_hold: result changed or grant seen within %0d stalled cycles", bp_cycles);
        else n_pass++;

        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        n_total++;
        if ({res_valid_o, gnt_o, busy_o} !== 4'b0000)
            $display("FAIL accept_idle: valid/gnt/busy=%b want 0000", {res_valid_o, gnt_o, busy_o});
        else n_pass++;
    endtask

    task automatic test_reset();
        n_total++;
        if ({gnt_o, pready_o, core_rst_o, core_x_o, core_y_o, res_valid_o, res_id_o, res_err_o,
             res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o, busy_o} !== {2'b00, 1'b0, 1'b1, 8'h00, 3'b000, 16'h0, 1'b0})
            $display("FAIL reset_values: gnt=%b pready=%b core_rst=%b busy=%b res_valid=%b", gnt_o, pready_o, core_rst_o, busy_o, res_valid_o);
        else n_pass++;
        n_total++;
        if (dbg_state_o !== 3'(ST_IDLE)) $display("FAIL reset_state: got %0d want %0d", dbg_state_o, ST_IDLE);
        else n_pass++;
    endtask

    task automatic test_contention();
        eng_en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            eng_res = 16'($urandom);
            eng_delay = $urandom_range(0, 8);
            do_job(2'b11, (j < 2), 1'b0, $urandom_range(2, 6), 1'b0);
        end
    endtask

    task automatic test_single();
        eng_en = 1'b1;
        eng_res = {4'd3, 4'd4, 4'd10, 4'd11};
        eng_delay = 5;
        do_job(2'b01, 1'b0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_timeout();
        eng_en = 1'b0;
        do_job(2'b10, 1'b0, 1'b1, 1, 1'b0);
        eng_en = 1'b1;
    endtask

    task automatic test_abort();
        logic [1:0] exp_gnt;
        bit ok;
        int wait_n;
        exp_gnt = model_pick(2'b01);
        req_i = 2'b01;
        wait_n = 0;
        while (gnt_o == 2'b00 && wait_n < 20) begin
            @(negedge clk_i);
            wait_n++;
        end
        n_total++;
        if (gnt_o !== exp_gnt) $display("FAIL abort_grant: got %b want %b", gnt_o, exp_gnt);
        else n_pass++;
        m_last = 0;
        for (int i = 0; i < 17; i++) begin
            pvalid_i = 1'b1;
            {px_i, py_i} = 8'($urandom);
            @(negedge clk_i);
        end
        pvalid_i = 1'b0;
        req_i = 2'b00;
        @(negedge clk_i);
        n_total++;
        if ({gnt_o, busy_o, core_rst_o} !== 4'b0001)
            $display("FAIL abort_release: gnt/busy/core_rst=%b want 0001", {gnt_o, busy_o, core_rst_o});
        else n_pass++;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (res_valid_o !== 1'b0 || core_rst_o !== 1'b1) ok = 1'b0;
            @(negedge clk_i);
        end
        n_total++;
        if (!ok) $display("FAIL abort_quiet: result or engine activity after abort");
        else n_pass++;
        eng_res = 16'($urandom);
        eng_delay = 2;
        do_job(2'b10, 1'b0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        eng_res = 16'($urandom);
        eng_delay = 3;
        do_job(2'b01, 1'b0, 1'b0, 50, 1'b1);
    endtask

    task automatic test_async_reset();
        logic [1:0] exp_gnt;
        int wait_n;
        exp_q.delete();
        exp_gnt = model_pick(2'b01);
        req_i = 2'b01;
        wait_n = 0;
        while (gnt_o == 2'b00 && wait_n < 20) begin
            @(negedge clk_i);
            wait_n++;
        end
        n_total++;
        if (gnt_o !== exp_gnt) $display("FAIL rst_job_grant: got %b want %b", gnt_o, exp_gnt);
        else n_pass++;
        for (int i = 0; i < NPTS; i++) begin
            pvalid_i = 1'b1;
            {px_i, py_i} = 8'($urandom);
            exp_q.push_back({px_i, py_i});
            @(negedge clk_i);
        end
        pvalid_i = 1'b0;
        wait_n = 0;
        while (core_rst_o !== 1'b0 && wait_n < 10) begin
            @(negedge clk_i);
            wait_n++;
        end
        repeat (20) @(negedge clk_i);
        n_total++;
        if ({core_rst_o, core_x_o, core_y_o} !== {1'b0, exp_q[20]})
            $display("FAIL burst_point20: rst=%b pt=%h want 0 %h", core_rst_o, {core_x_o, core_y_o}, exp_q[20]);
        else n_pass++;
        #2 rst_n_i = 1'b0;
        #1;
        n_total++;
        if ({gnt_o, pready_o, core_rst_o, core_x_o, core_y_o, res_valid_o, res_id_o, res_err_o,
             res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o, busy_o} !== {2'b00, 1'b0, 1'b1, 8'h00, 3'b000, 16'h0, 1'b0})
            $display("FAIL async_reset: core_rst=%b busy=%b core_pt=%h", core_rst_o, busy_o, {core_x_o, core_y_o});
        else n_pass++;
        req_i = 2'b00;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        m_last = 1;
        @(negedge clk_i);
        n_total++;
        if ({busy_o, core_rst_o, res_valid_o} !== 3'b010)
            $display("FAIL after_reset: busy/core_rst/valid=%b want 010", {busy_o, core_rst_o, res_valid_o});
        else n_pass++;
    endtask

    initial begin
        rst_n_i = 1'b0; req_i = 2'b00; pvalid_i = 1'b0; px_i = 4'h0; py_i = 4'h0;
        res_ready_i = 1'b0; stray_done = 1'b0; eng_en = 1'b1; eng_delay = 0; eng_res = 16'h0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_abort();
        test_backpressure();
        test_async_reset();
        test_contention();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
